// File: rtl/host_cmd_arbiter.sv
// Two-requester front end for the single-outstanding host RX command datapath.
// Round-robin by default; define HOST_PRIORITY_EN for fixed host-first priority.
module host_cmd_arbiter #(
  parameter int unsigned DATA_WIDTH     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMER_WIDTH    = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  resp0_valid,
  output logic                  resp1_valid,
  output logic                  resp_error,
  output logic [DATA_WIDTH-1:0] dp_input_data,
  output logic                  dp_send_packet,
  input  logic                  dp_done,
  input  logic                  dp_error,
  output logic                  busy,
  output logic                  timeout_flag
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                  state_q;
  logic                    last_grant_q;
  logic                    owner_q;
  logic                    done_armed_q;
  logic [TIMER_WIDTH-1:0]  timer_q;
  logic [DATA_WIDTH-1:0]   pkt_q;
  logic                    send_q;
  logic                    resp0_q;
  logic                    resp1_q;
  logic                    resp_err_q;
  logic                    busy_q;
  logic                    tflag_q;
  logic                    grant;

  // Grant index; only meaningful while at least one request is valid.
  always_comb begin
    grant = 1'b0;
`ifdef HOST_PRIORITY_EN
    grant = ~req0_valid;
`else
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
`endif
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      done_armed_q <= 1'b0;
      timer_q      <= '0;
      pkt_q        <= '0;
      send_q       <= 1'b0;
      resp0_q      <= 1'b0;
      resp1_q      <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      tflag_q      <= 1'b0;
    end else begin
      send_q  <= 1'b0;
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            pkt_q   <= req1_ready ? req1_data : req0_data;
            owner_q <= req1_ready;
            tflag_q <= 1'b0;
            send_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q      <= '0;
          done_armed_q <= 1'b0;
          state_q      <= WAIT;
        end
        WAIT: begin
          // A stale high done from the previous packet is ignored until a low is seen.
          if (done_armed_q && dp_done) begin
            resp_err_q <= dp_error;
            resp0_q    <= ~owner_q;
            resp1_q    <= owner_q;
            state_q    <= RESP;
          end else if (timer_q == TIMER_LAST) begin
            resp_err_q <= 1'b1;
            tflag_q    <= 1'b1;
            resp0_q    <= ~owner_q;
            resp1_q    <= owner_q;
            state_q    <= RESP;
          end else begin
            timer_q <= timer_q + TIMER_WIDTH'(1);
            if (!dp_done) done_armed_q <= 1'b1;
          end
        end
        RESP: begin
          last_grant_q <= owner_q;
          resp_err_q   <= 1'b0;
          pkt_q        <= '0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp0_valid    = resp0_q;
  assign resp1_valid    = resp1_q;
  assign resp_error     = resp_err_q;
  assign dp_input_data  = pkt_q;
  assign dp_send_packet = send_q;
  assign busy           = busy_q;
  assign timeout_flag   = tflag_q;

endmodule

// File: tb/tb_host_cmd_arbiter.sv
// Bench for host_cmd_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant order and response timing.
module tb_host_cmd_arbiter;

  localparam int unsigned DW = 128;
  localparam int unsigned TO = 8;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          resp0_valid, resp1_valid, resp_error;
  logic [DW-1:0] dp_input_data;
  logic          dp_send_packet, dp_done, dp_error, busy, timeout_flag;

  int checks = 0;
  int errors = 0;

  // Model state
  int model_last = 1;
  bit model_tflag = 1'b0;

  host_cmd_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TIMER_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_error(resp_error),
    .dp_input_data(dp_input_data), .dp_send_packet(dp_send_packet),
    .dp_done(dp_done), .dp_error(dp_error), .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input bit v0, input bit v1);
`ifdef HOST_PRIORITY_EN
    return v0 ? 0 : 1;
`else
    if (v0 && v1) return 1 - model_last;
    return v1 ? 1 : 0;
`endif
  endfunction

  // Datapath done level in WAIT cycle w: stale-high for s cycles, low until r, then high.
  function automatic logic done_profile(input int w, input int s, input int r);
    if (w < s) return 1'b1;
    if (w < r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction, entered and left on a negedge while the DUT is idle.
  task automatic run_txn(input bit v0, input bit v1, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1, input int s, input int r, input bit err);
    int g, wexit, n_exp, n_resp;
    bit done_ok, exp_err;
    logic [DW-1:0] exp_data;
    g        = model_grant(v0, v1);
    exp_data = (g == 0) ? d0 : d1;
    done_ok  = (s < r) && (r <= int'(TO) - 1);
    wexit    = done_ok ? r : int'(TO) - 1;
    n_exp    = wexit + 2;
    exp_err  = done_ok ? err : 1'b1;

    dp_done = (s > 0); dp_error = err;
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    #1;
    check_bit("req0_ready", req0_ready, v0 && g == 0);
    check_bit("req1_ready", req1_ready, v1 && g == 1);

    @(negedge clk);
    if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    check_bit("issue_send", dp_send_packet, 1'b1);
    check_val("issue_data", dp_input_data, exp_data);
    check_bit("issue_busy", busy, 1'b1);
    check_bit("issue_tflag", timeout_flag, 1'b0);
    check_bit("busy_ready0", req0_ready, 1'b0);
    check_bit("busy_ready1", req1_ready, 1'b0);

    n_resp = -1;
    for (int n = 1; n <= int'(TO) + 6; n++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) begin
        n_resp = n;
        break;
      end
      check_bit("wait_send", dp_send_packet, 1'b0);
      check_bit("wait_ready", req0_ready | req1_ready, 1'b0);
      dp_done = done_profile(n - 1, s, r);
    end
    check_int("resp_cycle", n_resp, n_exp);
    check_bit("resp0_valid", resp0_valid, g == 0);
    check_bit("resp1_valid", resp1_valid, g == 1);
    check_bit("resp_error", resp_error, exp_err);
    check_bit("resp_tflag", timeout_flag, !done_ok);
    check_val("resp_data", dp_input_data, exp_data);

    model_last  = g;
    model_tflag = !done_ok;
    @(negedge clk);
    check_bit("idle_busy", busy, 1'b0);
    check_bit("idle_resp", resp0_valid | resp1_valid, 1'b0);
    check_bit("idle_err", resp_error, 1'b0);
    check_val("idle_data", dp_input_data, '0);
    check_bit("idle_tflag", timeout_flag, model_tflag);
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; dp_done = 1'b0; dp_error = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_last  = 1;
    model_tflag = 1'b0;
  endtask

  initial begin
    bit v0, v1, e;
    int s, r;
    logic [DW-1:0] host_pkt, poll_pkt, inv_pkt;
    host_pkt = DW'(72'h0101FFFFFFFFFFFF01);
    poll_pkt = DW'(56'hFF27FF27FF2703);
    inv_pkt  = DW'(56'hFF27FF27FF2705);
    req0_data = '0; req1_data = '0;

    // Reset values
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; dp_done = 1'b0; dp_error = 1'b0;
    #3;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_send", dp_send_packet, 1'b0);
    check_bit("rst_resp", resp0_valid | resp1_valid, 1'b0);
    check_bit("rst_err", resp_error, 1'b0);
    check_bit("rst_tflag", timeout_flag, 1'b0);
    check_val("rst_data", dp_input_data, '0);
    apply_reset();

    // Host packet, done three cycles after send
    run_txn(1'b1, 1'b0, host_pkt, poll_pkt, 0, 2, 1'b0);

    // Contention, four rounds after a fresh reset
    apply_reset();
    for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, rand_data(), poll_pkt, 0, 1, 1'b0);

    // Stale done through ISSUE, one low cycle, re-rise with error
    req0_valid = 1'b0;
    run_txn(1'b0, 1'b1, '0, inv_pkt, 3, 4, 1'b1);

    // Done never returns: timeout, flag held until next handshake
    run_txn(1'b1, 1'b0, rand_data(), '0, 0, 1000, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("tflag_sticky", timeout_flag, 1'b1);
    run_txn(1'b0, 1'b1, '0, poll_pkt, 0, 1, 1'b0);

    // Counted done on the last timer cycle wins over the timeout
    run_txn(1'b1, 1'b0, rand_data(), '0, 0, int'(TO) - 1, 1'b0);

    // Reset during WAIT
    req0_valid = 1'b1; req0_data = rand_data(); req1_valid = 1'b0; dp_done = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_send", dp_send_packet, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_last = 1; model_tflag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_bit("midrst_noresp", resp0_valid | resp1_valid, 1'b0);
    end
    run_txn(1'b0, 1'b1, '0, poll_pkt, 0, 1, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      s  = int'($urandom_range(0, 2));
      r  = s + int'($urandom_range(0, TO + 1));
      e  = 1'($urandom_range(0, 1));
      run_txn(v0, v1, rand_data(), rand_data(), s, r, e);
    end

    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
